// File: rtl/piccolo_arb_ctrl.sv
// piccolo_arb_ctrl
// ----------------
// Two-requester round-robin front end and sequencer for one shared iterative
// Piccolo encryption core. A job (plaintext + 80/128-bit variant select) is
// taken from one requester, handed to the core with a one-cycle load pulse,
// the core's fixed iteration time is counted out, and the ciphertext is
// returned on a single response channel tagged with the requester ID.
// Only one job is in flight at a time.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   req0_* / req1_*            valid/ready job channels; version 0 = Piccolo-80,
//                              1 = Piccolo-128; pt is the 64-bit plaintext
//   rsp_valid/rsp_ready        response handshake; rsp_id names the owner of rsp_ct
//   busy                       high whenever a job is being processed
//   core_load                  one-cycle load pulse into the core
//   core_version, core_pt      job presented to the core, stable from load to load
//   core_ct                    ciphertext from the core
//
// Parameters
//   CYC80, CYC128              core cycles from load until core_ct is valid (1..15)

module piccolo_arb_ctrl #(
  parameter int CYC80  = 3,
  parameter int CYC128 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_version,
  input  logic [63:0] req0_pt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_version,
  input  logic [63:0] req1_pt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_ct,
  output logic        busy,
  output logic        core_load,
  output logic        core_version,
  output logic [63:0] core_pt,
  input  logic [63:0] core_ct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] CNT80  = 4'(CYC80);
  localparam logic [3:0] CNT128 = 4'(CYC128);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        job_id_q, job_id_d;
  logic        core_load_q, core_load_d;
  logic        core_version_q, core_version_d;
  logic [63:0] core_pt_q, core_pt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [63:0] rsp_ct_q, rsp_ct_d;

  logic        gnt1_s;
  logic        accept_s;

  // Grant selection and ready outputs; requests are only looked at in IDLE.
  always_comb begin
    gnt1_s     = 1'b0;
    accept_s   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == S_IDLE) begin
      // Requester 1 wins when it is alone, or when both ask and it holds priority.
      gnt1_s     = req1_valid & (~req0_valid | ptr_q);
      accept_s   = req0_valid | req1_valid;
      req0_ready = req0_valid & ~gnt1_s;
      req1_ready = gnt1_s;
    end else begin
      gnt1_s     = 1'b0;
      accept_s   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Next-state and datapath register updates for the job sequencer.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    job_id_d       = job_id_q;
    core_load_d    = 1'b0;
    core_version_d = core_version_q;
    core_pt_d      = core_pt_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_ct_d       = rsp_ct_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          // The job registers double as the core inputs, so core_pt/core_version
          // change exactly when the LOAD cycle begins and then hold.
          job_id_d       = gnt1_s;
          core_version_d = gnt1_s ? req1_version : req0_version;
          core_pt_d      = gnt1_s ? req1_pt : req0_pt;
          core_load_d    = 1'b1;
          state_d        = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = core_version_q ? CNT128 : CNT80;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_valid_d = 1'b1;
          rsp_ct_d    = core_ct;
          rsp_id_d    = job_id_q;
          state_d     = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Priority moves to the requester that was not just served.
          ptr_d       = ~rsp_id_q;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= 1'b0;
      cnt_q          <= 4'd0;
      job_id_q       <= 1'b0;
      core_load_q    <= 1'b0;
      core_version_q <= 1'b0;
      core_pt_q      <= 64'd0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_ct_q       <= 64'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      job_id_q       <= job_id_d;
      core_load_q    <= core_load_d;
      core_version_q <= core_version_d;
      core_pt_q      <= core_pt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_ct_q       <= rsp_ct_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign core_load    = core_load_q;
  assign core_version = core_version_q;
  assign core_pt      = core_pt_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_ct       = rsp_ct_q;

  piccolo_arb_ctrl_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .busy       (busy),
    .core_load  (core_load),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready)
  );

endmodule

// piccolo_arb_ctrl_chk
// --------------------
// Protocol properties of the arbiter/sequencer: exclusive grants, a single
// load pulse per job, and a response that stays up until it is taken.
// Inputs mirror the corresponding piccolo_arb_ctrl signals.
module piccolo_arb_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic req0_ready,
  input logic req1_ready,
  input logic busy,
  input logic core_load,
  input logic rsp_valid,
  input logic rsp_ready
);

  a_ready_excl: assert property (@(posedge clk) disable iff (reset)
    !(req0_ready && req1_ready));

  a_ready_idle: assert property (@(posedge clk) disable iff (reset)
    (req0_ready || req1_ready) |-> !busy);

  a_load_busy: assert property (@(posedge clk) disable iff (reset)
    core_load |-> busy);

  a_load_pulse: assert property (@(posedge clk) disable iff (reset)
    core_load |=> !core_load);

  a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> rsp_valid);

endmodule

// File: tb/tb_piccolo_arb_ctrl.sv
module tb_piccolo_arb_ctrl;

  localparam int CYC80  = 3;
  localparam int CYC128 = 4;
  localparam logic [63:0] MASK80  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] MASK128 = 64'hBBBB_BBBB_BBBB_BBBB;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_version;
  logic [63:0] req0_pt;
  logic        req1_valid, req1_ready, req1_version;
  logic [63:0] req1_pt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_ct;
  logic        busy, core_load, core_version;
  logic [63:0] core_pt, core_ct;

  piccolo_arb_ctrl #(.CYC80(CYC80), .CYC128(CYC128)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_version(req0_version), .req0_pt(req0_pt),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_version(req1_version), .req1_pt(req1_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ct(rsp_ct),
    .busy(busy), .core_load(core_load), .core_version(core_version),
    .core_pt(core_pt), .core_ct(core_ct)
  );

  always #5 clk = ~clk;

  // Core stub: latch plaintext on load, output it XORed with a per-variant mask.
  logic [63:0] stub_pt = 64'd0;
  always @(posedge clk) if (core_load) stub_pt <= core_pt;
  assign core_ct = stub_pt ^ (core_version ? MASK128 : MASK80);

  function automatic logic [63:0] model_ct(input logic ver, input logic [63:0] pt);
    return pt ^ (ver ? MASK128 : MASK80);
  endfunction

  int nchecks = 0;
  int nerrors = 0;
  int accepts = 0;
  int rsps    = 0;
  int dropped = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [63:0] ct;
  } rsp_t;
  rsp_t sb[$];

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    if (reset) begin
      dropped += sb.size();
      sb.delete();
    end else begin
      if (req0_ready || req1_ready) check("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, model_ct(req0_version, req0_pt)});
        accepts++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, model_ct(req1_version, req1_pt)});
        accepts++;
      end
      if (rsp_valid && rsp_ready) begin
        rsps++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("sb_id", {63'd0, rsp_id}, {63'd0, e.id});
          check("sb_ct", rsp_ct, e.ct);
        end
      end
    end
  end

  task automatic drive_req(input logic id, input logic v, input logic ver, input logic [63:0] pt);
    if (id) begin
      req1_valid = v; req1_version = ver; req1_pt = pt;
    end else begin
      req0_valid = v; req0_version = ver; req0_pt = pt;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Single job with cycle-accurate load/response timing checks.
  task automatic run_job(input logic id, input logic ver, input logic [63:0] pt,
                         input logic [63:0] exp_ct, input int exp_lat);
    logic seen;
    int   loads;
    @(posedge clk); #1;
    drive_req(id, 1'b1, ver, pt);
    @(negedge clk);
    check("accept_ready", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
    @(posedge clk); #1;
    drive_req(id, 1'b0, ~ver, ~pt);
    seen  = 1'b0;
    loads = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (core_load) begin
        loads++;
        check("load_cycle", 64'(c), 64'd1);
        check("core_pt", core_pt, pt);
        check("core_version", {63'd0, core_version}, {63'd0, ver});
      end
      if (rsp_valid) begin
        seen = 1'b1;
        check("rsp_latency", 64'(c), 64'(exp_lat));
        check("rsp_id", {63'd0, rsp_id}, {63'd0, id});
        check("rsp_ct", rsp_ct, exp_ct);
      end
    end
    check("load_count", 64'(loads), 64'd1);
    check("rsp_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
    check("idle_after_rsp", {63'd0, busy}, 64'd0);
  endtask

  // Both requesters valid for part of a cycle, then withdrawn before the edge.
  task automatic probe_ptr(input logic exp_winner);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("probe_ready0", {63'd0, req0_ready}, {63'd0, ~exp_winner});
    check("probe_ready1", {63'd0, req1_ready}, {63'd0, exp_winner});
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  typedef struct {
    logic        id;
    logic        ver;
    logic [63:0] pt;
    logic [63:0] exp_ct;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hold_id;
    logic [63:0] hold_ct;
    logic [63:0] bp_pt;
    logic [1:0]  order[4];
    int          n, base, c;

    vecs[0] = '{1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hAB89_EFCD_2301_6745, 5};
    vecs[1] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4444_4444_4444_4444, 6};
    vecs[2] = '{1'b1, 1'b0, 64'h0000_0000_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 5};
    vecs[3] = '{1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, 64'h4567_0123_CDEF_89AB, 6};

    reset = 1'b1;
    req0_valid = 1'b0; req0_version = 1'b0; req0_pt = 64'd0;
    req1_valid = 1'b0; req1_version = 1'b0; req1_pt = 64'd0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
    check("rst_rsp_ct", rsp_ct, 64'd0);
    check("rst_core_load", {63'd0, core_load}, 64'd0);
    check("rst_core_version", {63'd0, core_version}, 64'd0);
    check("rst_core_pt", core_pt, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contention: both valid continuously, expect 0,1,0,1.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_version = 1'b0; req0_pt = 64'h1111_2222_3333_4444;
    req1_valid = 1'b1; req1_version = 1'b1; req1_pt = 64'h5555_6666_7777_8888;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (req0_ready) begin order[n] = 2'd0; n++; end
      else if (req1_ready) begin order[n] = 2'd1; n++; end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contention_jobs", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) check("grant_order", {62'd0, order[k]}, 64'(k % 2));
    wait_idle();

    // Table-driven single jobs.
    for (int i = 0; i < 4; i++) run_job(vecs[i].id, vecs[i].ver, vecs[i].pt, vecs[i].exp_ct, vecs[i].lat);

    // Backpressure: hold response for 10 cycles.
    bp_pt = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 1'b1, bp_pt);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    c = 0;
    @(negedge clk);
    while (!rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_rsp_ct", rsp_ct, model_ct(1'b1, bp_pt));
    hold_ct = rsp_ct;
    hold_id = rsp_id;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_hold_ct", rsp_ct, hold_ct);
      check("bp_hold_id", {63'd0, rsp_id}, {63'd0, hold_id});
      check("bp_busy", {63'd0, busy}, 64'd1);
      check("bp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      if (k < 9) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle", {63'd0, busy}, 64'd0);
    check("bp_rsp_clear", {63'd0, rsp_valid}, 64'd0);

    // Pointer after serving requester 0 favours requester 1.
    probe_ptr(1'b1);

    // Reset in RUN (cycle 3 of a job).
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_run_busy", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_run_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_run_busy_low", {63'd0, busy}, 64'd0);
    probe_ptr(1'b0);
    run_job(1'b1, 1'b0, 64'h0011_2233_4455_6677, 64'hAABB_8899_EEFF_CCDD, 5);

    // Random mixed traffic through the scoreboard.
    base = rsps;
    for (int k = 0; k < 20000 && (rsps - base) < 200; k++) begin
      @(posedge clk); #1;
      req0_valid   = 1'($urandom_range(0, 1));
      req1_valid   = 1'($urandom_range(0, 1));
      req0_version = 1'($urandom_range(0, 1));
      req1_version = 1'($urandom_range(0, 1));
      req0_pt      = {$urandom(), $urandom()};
      req1_pt      = {$urandom(), $urandom()};
      rsp_ready    = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    check("random_rsp_count", {63'd0, (rsps - base) >= 200}, 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("no_lost_rsp", 64'(accepts), 64'(rsps + dropped));
    check("dropped_jobs", 64'(dropped), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
